// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: two-stage pipelined ALU with registered status flags and a
// persistent carry. The carry lets a narrow datapath chain multi-word
// add/subtract through ADC/SBC sequences.
//
// Handshake: a transfer happens on a port only in a cycle where valid and
// ready are both high at the rising edge. Once a source raises valid, it
// holds valid and payload stable until that transfer. This block never drops
// out_valid or changes out_y/flags until the consumer takes the result.
// in_ready is a combinational function of pipeline occupancy and out_ready.
module alu_pipe_flags #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         carry_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_z,
  output logic         out_n,
  output logic         out_c,
  output logic         out_v,
  output logic         carry_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  // Stage 1: captured operands and opcode
  logic         s1_valid;
  logic [2:0]   s1_op;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s1_clr;

  // Stage 2 valid; the result registers are the outputs themselves
  logic         s2_valid;

  logic advance1;
  logic advance2;

  // Combinational result of the op held in S1
  logic         cin;
  logic [W-1:0] b_eff;
  logic         c_seed;
  logic [W:0]   sum;
  logic [W-1:0] res_y;
  logic         res_c;
  logic         res_v;

  // Stage enables: a stage may load when it is empty or its content moves on
  always_comb begin
    advance2 = ~s2_valid | out_ready;
    advance1 = ~s1_valid | advance2;
  end

  assign in_ready  = advance1;
  assign out_valid = s2_valid;

  // Execute the S1 op: shared adder for add/sub, carry passes through logic ops
  always_comb begin
    cin    = s1_clr ? 1'b0 : carry_q;
    b_eff  = s1_op[1] ? ~s1_b : s1_b;
    c_seed = 1'b0;
    case (s1_op)
      OP_ADD:  c_seed = 1'b0;
      OP_ADC:  c_seed = cin;
      OP_SUB:  c_seed = 1'b1;
      OP_SBC:  c_seed = cin;
      default: c_seed = 1'b0;
    endcase
    sum   = {1'b0, s1_a} + {1'b0, b_eff} + {{W{1'b0}}, c_seed};
    res_y = sum[W-1:0];
    res_c = sum[W];
    res_v = (s1_a[W-1] == b_eff[W-1]) & (sum[W-1] != s1_a[W-1]);
    case (s1_op)
      OP_AND: begin
        res_y = s1_a & s1_b;
        res_c = cin;
        res_v = 1'b0;
      end
      OP_OR: begin
        res_y = s1_a | s1_b;
        res_c = cin;
        res_v = 1'b0;
      end
      OP_XOR: begin
        res_y = s1_a ^ s1_b;
        res_c = cin;
        res_v = 1'b0;
      end
      OP_NOR: begin
        res_y = ~(s1_a | s1_b);
        res_c = cin;
        res_v = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage 1 register: take a new op whenever the stage can advance
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= 3'b000;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_clr   <= 1'b0;
    end else if (advance1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_clr <= carry_clr;
      end
    end
  end

  // Stage 2 register and stored carry: results and carry commit together, in order
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_y    <= '0;
      out_z    <= 1'b0;
      out_n    <= 1'b0;
      out_c    <= 1'b0;
      out_v    <= 1'b0;
      carry_q  <= 1'b0;
    end else if (advance2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_y   <= res_y;
        out_z   <= (res_y == '0);
        out_n   <= res_y[W-1];
        out_c   <= res_c;
        out_v   <= res_v;
        carry_q <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Directed testbench for alu_pipe_flags (W=8) with hand-computed expectations.
module tb_alu_pipe_flags;

  localparam int W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;
  localparam logic [2:0] OP_OR  = 3'b101;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'b000;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         carry_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_y;
  logic         out_z;
  logic         out_n;
  logic         out_c;
  logic         out_v;
  logic         carry_q;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // expected results as {y, z, n, c, v}
  logic [11:0] exp_q[$];
  int          xfer_q[$];
  logic [11:0] exp_front;
  logic [11:0] got_pk;
  int          diff;

  alu_pipe_flags #(.W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .carry_clr (carry_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_c     (out_c),
    .out_v     (out_v),
    .carry_q   (carry_q)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign got_pk = {out_y, out_z, out_n, out_c, out_v};

  function automatic logic [11:0] pk(input logic [7:0] y, input logic z,
                                     input logic n, input logic c, input logic v);
    return {y, z, n, c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_res(input logic [7:0] y, input logic z, input logic n,
                            input logic c, input logic v);
    exp_q.push_back(pk(y, z, n, c, v));
  endtask

  // driver: present one op and hold it until accepted (bounded wait)
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic clr);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    carry_clr = clr;
    @(negedge clock);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    carry_clr = 1'b0;
  endtask

  // scoreboard: every output transfer must match the next expected result
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      xfer_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(got_pk), 32'hFFFF_FFFF);
      end else begin
        exp_front = exp_q.pop_front();
        check("result", 32'(got_pk), 32'(exp_front));
      end
    end
  end

  initial begin
    // reset
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'(got_pk), 32'd0);
    check("rst_carry_q", 32'(carry_q), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // latency: ADD FF+01
    out_ready = 1'b1;
    in_op = OP_ADD; in_a = 8'hFF; in_b = 8'h01; carry_clr = 1'b0; in_valid = 1'b1;
    expect_res(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    check("lat_edge2", 32'(out_valid), 32'd1);
    check("lat_carry_q", 32'(carry_q), 32'd1);
    repeat (3) @(posedge clock);
    #1;

    // 16-bit chain: 0x12FF + 0x3401 = 0x4700
    xfer_q.delete();
    expect_res(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_res(8'h47, 1'b0, 1'b0, 1'b0, 1'b0);
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    send(OP_ADC, 8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    check("chain_count", 32'(xfer_q.size()), 32'd2);
    diff = (xfer_q.size() >= 2) ? (xfer_q[1] - xfer_q[0]) : 0;
    check("chain_consec", 32'(diff), 32'd1);
    check("chain_carry_q", 32'(carry_q), 32'd0);

    // subtract / overflow vectors
    expect_res(8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    send(OP_SUB, 8'h05, 8'h07, 1'b0);
    expect_res(8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    send(OP_SUB, 8'h80, 8'h01, 1'b0);
    expect_res(8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    send(OP_ADD, 8'h7F, 8'h01, 1'b0);

    // carry_clr and logic ops
    expect_res(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    expect_res(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    send(OP_ADC, 8'h01, 8'h01, 1'b1);
    expect_res(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    expect_res(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    send(OP_XOR, 8'hF0, 8'hFF, 1'b0);
    expect_res(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    send(OP_SBC, 8'h10, 8'h01, 1'b0);
    expect_res(8'h0C, 1'b0, 1'b0, 1'b1, 1'b0);
    send(OP_AND, 8'h3C, 8'h0F, 1'b0);
    expect_res(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    send(OP_NOR, 8'h00, 8'h00, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    check("logic_carry_q", 32'(carry_q), 32'd0);

    // backpressure: 4 ops with out_ready low, then release
    out_ready = 1'b0;
    expect_res(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_res(8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_res(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_res(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(OP_ADD, 8'h01, 8'h02, 1'b0);
    send(OP_ADD, 8'h10, 8'h20, 1'b0);
    @(negedge clock);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_y", 32'(out_y), 32'h03);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_hold", 32'({out_valid, got_pk}), 32'({1'b1, pk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0)}));
    end
    @(posedge clock);
    #1;
    fork
      begin
        send(OP_OR, 8'h0F, 8'hF0, 1'b0);
        send(OP_XOR, 8'hAA, 8'hAA, 1'b0);
      end
      begin
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clock);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);

    // reset with two ops in flight: nothing may come out afterwards
    out_ready = 1'b0;
    send(OP_ADD, 8'hFF, 8'hFF, 1'b0);
    send(OP_ADD, 8'h01, 8'h01, 1'b0);
    check("rst_mid_pre_valid", 32'(out_valid), 32'd1);
    check("rst_mid_pre_carry", 32'(carry_q), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_carry_q", 32'(carry_q), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_mid_no_stale", 32'(out_valid), 32'd0);
    end

    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    check("global_timeout", 32'd1, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "time limit reached");
  end

endmodule
